decoder_rr_arbiter: RTL and testbench
=====================================

DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum cycles one grant is held before forced release (legal 2..255).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: req  input  4  request per requester; bit i = requester i.
REQ-005 Port: done  input  1  current grantee finished; meaningful only while gnt_valid=1.
REQ-006 Port: gnt  output  4  one-hot grant; all-zero when no grant.
REQ-007 Port: gnt_idx  output  2  binary index of current grantee; 0 when gnt_valid=0.
REQ-008 Port: gnt_valid  output  1  a grant is active.
REQ-009 Port: timeout  output  1  one-cycle pulse on forced release at MAX_HOLD.

Function
REQ-010 FSM has exactly two states: IDLE (no grant) and BUSY (grant held).
REQ-011 In IDLE with req != 0: choose first set bit scanning ptr, ptr+1, ... mod 4; next cycle enter BUSY with gnt_idx = winner, gnt_valid = 1.
REQ-012 Grant latency: req sampled at edge N -> gnt visible after edge N+1; no combinational req->gnt path.
REQ-013 In IDLE with req == 0: remain IDLE, outputs zero, ptr unchanged.
REQ-014 BUSY entry clears hold_cnt to 0; hold_cnt increments each BUSY cycle.
REQ-015 Release from BUSY when done=1, or req[gnt_idx]=0, or hold_cnt == MAX_HOLD-1; next state IDLE.
REQ-016 Timeout release only: assert timeout for the cycle following the release edge (aligned with gnt_valid=0).
REQ-017 done=1 or req drop in the same cycle as hold_cnt == MAX_HOLD-1: normal release, timeout stays 0.
REQ-018 On any release, ptr <= gnt_idx + 1 mod 4 (2-bit wrap, 3 -> 0).
REQ-019 At least one IDLE cycle between consecutive grants (gnt never changes one-hot to one-hot directly).
REQ-020 done while gnt_valid=0 is ignored; req changes of non-grantees during BUSY are ignored.
REQ-021 gnt = decode(gnt_idx) gated by gnt_valid; gnt always one-hot or zero.
REQ-022 Starvation bound: an asserted, held request is granted within 4 grants.

Reset
REQ-023 rst_n low: immediately (asynchronously) state = IDLE, ptr = 0, hold_cnt = 0, gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0.
REQ-024 Reset mid-grant aborts the grant without a timeout pulse; first decision after rst_n deassert uses ptr = 0.
REQ-025 Operation resumes on the first rising clk edge with rst_n high.

Structure
REQ-026 Package arb_pkg holds NUM_REQ = 4, IDX_W = 2, and the state enum typedef (IDLE, BUSY).
REQ-027 One sub-module: the team's decoder2x4 (inputs a,b = gnt_idx[1],gnt_idx[0]; outputs y0..y3), with outputs ANDed with gnt_valid to form gnt.
REQ-028 Priority scan, FSM, ptr and hold counter reside in decoder_rr_arbiter; hold counter width 8 bits.

Verification
REQ-029 After reset, req=4'b0101 held, done pulsed 2 cycles after each grant -> grant order 0,2,0,2; gnt 4'b0001 / 4'b0100; one IDLE cycle between grants.
REQ-030 req=4'b1111 held, done every grant -> gnt_idx sequence 0,1,2,3,0 (ptr wraps 3->0).
REQ-031 MAX_HOLD=8, req=4'b0010 held, done=0 -> gnt=4'b0010 for exactly 8 cycles, then gnt=0 with timeout=1 for 1 cycle, then re-grant to 1.
REQ-032 Grant to 2, done=1 on the cycle hold_cnt=7 (MAX_HOLD=8) -> release, timeout stays 0, ptr=3.
REQ-033 Grant to 3, rst_n pulsed low mid-grant -> outputs 0 immediately, no timeout; req=4'b1000 after reset -> grant to 3 after the scan starts at ptr=0.
REQ-034 Grant to 1, req[1] drops with done=0 -> gnt=0 next cycle, timeout=0; done=1 asserted while idle -> no effect.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin grant arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int HOLD_W  = 8;

  // Arbiter control states: IDLE has no grant, BUSY holds one grant.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/decoder2x4.sv
// Plain 2-to-4 line decoder; a is the index MSB, b the LSB.
module decoder2x4 (
  input  logic a,
  input  logic b,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  // One output high for each of the four input codes.
  always_comb begin
    y0 = ~a & ~b;
    y1 = ~a &  b;
    y2 =  a & ~b;
    y3 =  a &  b;
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time. A grant is
// decided in IDLE, held in BUSY until done, request drop or the hold
// limit, and every release passes through IDLE before the next grant.
module decoder_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  holdCnt_q, holdCnt_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic               holdExpired;
  logic               grantKept;
  logic               releaseGrant;
  logic               forcedRelease;
  logic               dec0, dec1, dec2, dec3;

  // Scan requesters starting at ptr and wrapping, first set bit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Release decisions; a timeout only counts when nothing else released.
  always_comb begin
    holdExpired   = (holdCnt_q == HOLD_LAST);
    grantKept     = req[idx_q] & ~done;
    releaseGrant  = (state_q == BUSY) & (~grantKept | holdExpired);
    forcedRelease = (state_q == BUSY) & grantKept & holdExpired;
  end

  // Next-state logic for the FSM, pointer, hold counter and timeout flag.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    holdCnt_d = holdCnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = BUSY;
          idx_d     = winner;
          holdCnt_d = '0;
        end
      end
      BUSY: begin
        if (releaseGrant) begin
          state_d   = IDLE;
          ptr_d     = idx_q + IDX_W'(1);
          idx_d     = '0;
          holdCnt_d = '0;
          timeout_d = forcedRelease;
        end else begin
          holdCnt_d = holdCnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any grant at once without a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Registered outputs only; the index reads zero whenever there is no grant.
  always_comb begin
    gnt_valid = (state_q == BUSY);
    gnt_idx   = gnt_valid ? idx_q : '0;
    timeout   = timeout_q;
  end

  decoder2x4 u_decoder (
    .a  (gnt_idx[1]),
    .b  (gnt_idx[0]),
    .y0 (dec0),
    .y1 (dec1),
    .y2 (dec2),
    .y3 (dec3)
  );

  // Decoded grant gated so it is all-zero outside BUSY.
  always_comb begin
    gnt = {dec3, dec2, dec1, dec0} & {NUM_REQ{gnt_valid}};
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_decoder_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checkCount;
  int errorCount;

  // Behavioural model: who holds the grant, for how many cycles, and
  // where the next round-robin scan starts.
  bit mBusy;
  int mOwner;
  int mPtr;
  int mHeld;
  bit mTimeout;

  // Observations of the DUT used by the scenario checks.
  int dutLog[$];
  bit prevValid;
  int timeoutSeen;

  decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mBusy    = 1'b0;
    mOwner   = 0;
    mPtr     = 0;
    mHeld    = 0;
    mTimeout = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic modelEdge();
    bit expired;
    if (mBusy) begin
      expired = (mHeld == MAX_HOLD);
      if (done || !req[mOwner] || expired) begin
        mTimeout = expired && !done && req[mOwner];
        mPtr     = (mOwner + 1) % 4;
        mBusy    = 1'b0;
      end else begin
        mHeld++;
        mTimeout = 1'b0;
      end
    end else begin
      mTimeout = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!mBusy && req[(mPtr + k) % 4]) begin
          mBusy  = 1'b1;
          mOwner = (mPtr + k) % 4;
          mHeld  = 1;
        end
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".gnt"},       32'(gnt),       mBusy ? (32'd1 << mOwner) : 32'd0);
    checkOutput({tag, ".gnt_idx"},   32'(gnt_idx),   mBusy ? 32'(mOwner) : 32'd0);
    checkOutput({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(mBusy));
    checkOutput({tag, ".timeout"},   32'(timeout),   32'(mTimeout));
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
    if (gnt_valid && !prevValid) dutLog.push_back(int'(gnt_idx));
    prevValid = gnt_valid;
    if (timeout) timeoutSeen++;
  endtask

  // Hold req for a number of cycles; donePolicy > 0 pulses done on that
  // cycle of each grant, 0 never asserts done, < 0 keeps done high.
  task automatic applyStimulus(input string tag, input logic [3:0] r,
                               input int donePolicy, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      req = r;
      if (donePolicy < 0) done = 1'b1;
      else done = (donePolicy > 0) && mBusy && (mHeld == donePolicy);
      stepCycle(tag);
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #3;
    modelReset();
    checkAll("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prevValid   = 1'b0;
    timeoutSeen = 0;
    dutLog.delete();
  endtask

  task automatic checkLog(input string tag, input int expected[$]);
    for (int i = 0; i < expected.size(); i++) begin
      checkOutput(tag, (i < dutLog.size()) ? 32'(dutLog[i]) : 32'hFFFF_FFFF,
                  32'(expected[i]));
    end
  endtask

  // Scenario sequence followed by a randomized run.
  initial begin
    checkCount  = 0;
    errorCount  = 0;
    rst_n       = 1'b0;
    req         = 4'b0000;
    done        = 1'b0;
    prevValid   = 1'b0;
    timeoutSeen = 0;
    modelReset();

    // Alternating pair with done two cycles into each grant.
    applyReset();
    applyStimulus("pair", 4'b0101, 2, 12);
    checkLog("pair.order", '{0, 2, 0, 2});

    // All requesting: pointer walks and wraps from 3 back to 0.
    applyReset();
    applyStimulus("all", 4'b1111, 1, 12);
    checkLog("all.order", '{0, 1, 2, 3, 0});

    // Single requester never finishing: forced releases at the hold limit.
    applyReset();
    applyStimulus("hold", 4'b0010, 0, 19);
    checkOutput("hold.timeouts", 32'(timeoutSeen), 32'd2);
    checkLog("hold.order", '{1, 1});

    // done on the last allowed cycle is a normal release; pointer moves to 3.
    applyReset();
    applyStimulus("lastdone", 4'b0100, MAX_HOLD, 9);
    applyStimulus("lastdone", 4'b1111, 1, 2);
    checkOutput("lastdone.timeouts", 32'(timeoutSeen), 32'd0);
    checkLog("lastdone.order", '{2, 3});

    // Reset asserted in the middle of a grant clears outputs immediately.
    applyReset();
    applyStimulus("midrst", 4'b1000, 0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("midrst.async");
    repeat (2) @(posedge clk);
    #1;
    checkAll("midrst.held");
    @(negedge clk);
    rst_n       = 1'b1;
    prevValid   = 1'b0;
    dutLog.delete();
    applyStimulus("midrst", 4'b1000, 0, 3);
    checkLog("midrst.order", '{3});
    checkOutput("midrst.timeouts", 32'(timeoutSeen), 32'd0);

    // Request drop releases without timeout; done while idle is ignored.
    applyReset();
    applyStimulus("drop", 4'b0010, 0, 3);
    applyStimulus("drop", 4'b0000, 0, 1);
    applyStimulus("idledone", 4'b0000, -1, 3);
    checkOutput("drop.timeouts", 32'(timeoutSeen), 32'd0);
    checkLog("drop.order", '{1});

    // Randomized traffic against the model.
    applyReset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 4) == 0);
      stepCycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
